// File: rtl/mult_iter_if.sv
// rtl/mult_iter_if.sv - request/result bundle between the execute stage and mult_iter
interface mult_iter_if #(
  parameter int WIDTH = 32
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2:0]           op;
  logic [2*WIDTH-1:0]   hilo_in;
  logic                 busy;
  logic                 out_valid;
  logic [2*WIDTH-1:0]   hilo;

  modport master (
    output flush, in_valid, a, b, op, hilo_in,
    input  in_ready, busy, out_valid, hilo
  );

  modport slave (
    input  flush, in_valid, a, b, op, hilo_in,
    output in_ready, busy, out_valid, hilo
  );
endinterface

// File: rtl/mult_iter.sv
// rtl/mult_iter.sv - iterative shift-add HI/LO multiplier with flush support
// Defining MULT_ACC_EN adds MADD/MSUB accumulation onto the hilo_in sampled at accept.
module mult_iter #(
  parameter int WIDTH = 32,
  parameter int BPC   = 4
) (
  input logic        clk,
  input logic        reset,
  mult_iter_if.slave bus
);
  localparam int ITER = WIDTH / BPC;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int PW   = 2 * WIDTH;

  if ((WIDTH % BPC) != 0) begin : g_bpc_check
    $error("mult_iter: WIDTH must be a multiple of BPC");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    hilo_q, hilo_d;
`ifdef MULT_ACC_EN
  logic [1:0]       fn_q, fn_d;
  logic [PW-1:0]    base_q, base_d;
`else
  logic             unused_acc;
  assign unused_acc = ^{bus.op[2:1], bus.hilo_in};
`endif

  logic             is_signed;
  logic             accept;
  logic             out_v;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    res;

  // Magnitudes stay unsigned WIDTH bits, so -2^(W-1) maps cleanly onto 2^(W-1).
  assign is_signed = bus.op[0];
  assign a_mag     = (is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign accept    = (state_q == S_IDLE) && bus.in_valid && !bus.flush;
  assign out_v     = (state_q == S_DONE) && !bus.flush;

  assign pp   = {{WIDTH{1'b0}}, a_mag_q} * {{(PW-BPC){1'b0}}, b_sh_q[BPC-1:0]};
  assign prod = neg_q ? -acc_q : acc_q;

  always_comb begin
    res = prod;
`ifdef MULT_ACC_EN
    case (fn_q)
      2'b01:   res = base_q + prod;
      2'b10:   res = base_q - prod;
      default: res = prod;
    endcase
`endif
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign bus.out_valid = out_v;
  assign bus.hilo      = out_v ? res : hilo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_mag_d = a_mag_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    hilo_d  = hilo_q;
`ifdef MULT_ACC_EN
    fn_d    = fn_q;
    base_d  = base_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_mag_d = a_mag;
          b_sh_d  = b_mag;
          neg_d   = is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
`ifdef MULT_ACC_EN
          fn_d    = bus.op[2:1];
          base_d  = bus.hilo_in;
`endif
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d  = acc_q + (pp << (BPC * cnt_q));
        b_sh_d = b_sh_q >> BPC;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (out_v) begin
      hilo_d = res;
    end
    // A squashed op leaves hilo untouched; out_v is already gated by flush.
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_mag_q <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      hilo_q  <= '0;
`ifdef MULT_ACC_EN
      fn_q    <= 2'b00;
      base_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_mag_q <= a_mag_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      hilo_q  <= hilo_d;
`ifdef MULT_ACC_EN
      fn_q    <= fn_d;
      base_q  <= base_d;
`endif
    end
  end
endmodule

// File: tb/tb_mult_iter.sv
// tb/tb_mult_iter.sv - directed checks for mult_iter (default and MULT_ACC_EN builds)
module tb_mult_iter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_iter_if #(.WIDTH(32)) bus ();
  mult_iter #(.WIDTH(32), .BPC(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] last_hilo = 64'd0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.a = '0; bus.b = '0;
    bus.op = 3'b000; bus.hilo_in = '0;
  endtask

  // Presents one request while idle; returns latency (edges from request to strobe) and result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [63:0] hin, output int lat, output logic [63:0] res,
                        output bit ok);
    ok = 1'b0; res = '0;
    bus.a = a; bus.b = b; bus.op = op; bus.hilo_in = hin; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = ~a; bus.b = b + 32'd1; bus.hilo_in = ~hin;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        res = bus.hilo; ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_vec++; if (bus.hilo !== 64'd0) begin n_bad++; $display("FAIL reset_hilo got=%h exp=0", bus.hilo); end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res; bit ok;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b000, 64'd0, lat, res, ok);
    n_vec++; if (!ok || lat != 9) begin n_bad++; $display("FAIL multu_latency got=%0d ok=%0d exp=9", lat, ok); end
    n_vec++; if (res !== 64'hFFFF_FFFE_0000_0001) begin n_bad++; $display("FAIL multu_max got=%h exp=fffffffe00000001", res); end
    last_hilo = 64'hFFFF_FFFE_0000_0001;
    @(negedge clk);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL strobe_width got=%b exp=0", bus.out_valid); end
    n_vec++; if (bus.hilo !== last_hilo) begin n_bad++; $display("FAIL hilo_hold got=%h exp=%h", bus.hilo, last_hilo); end
    @(posedge clk); #1;
    run_op(32'h8000_0000, 32'h0000_0002, 3'b000, 64'd0, lat, res, ok);
    n_vec++; if (!ok || res !== 64'h0000_0001_0000_0000) begin n_bad++; $display("FAIL multu_msb got=%h exp=0000000100000000", res); end
    last_hilo = res;
  endtask

  task automatic test_signed();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [63:0] ve [4];
    int lat; logic [63:0] res; bit ok;
    va[0] = 32'h8000_0000; vb[0] = 32'h8000_0000; ve[0] = 64'h4000_0000_0000_0000;
    va[1] = 32'hFFFF_FFFD; vb[1] = 32'h0000_0007; ve[1] = 64'hFFFF_FFFF_FFFF_FFEB;
    va[2] = 32'h0000_0005; vb[2] = 32'hFFFF_FFFC; ve[2] = 64'hFFFF_FFFF_FFFF_FFEC;
    va[3] = 32'h8000_0000; vb[3] = 32'hFFFF_FFFF; ve[3] = 64'h0000_0000_8000_0000;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], 3'b001, 64'd0, lat, res, ok);
      n_vec++;
      if (!ok || lat != 9 || res !== ve[i]) begin
        n_bad++; $display("FAIL mult_signed[%0d] got=%h lat=%0d exp=%h", i, res, lat, ve[i]);
      end
      last_hilo = ve[i];
    end
  endtask

  task automatic test_accumulate();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [2:0]  vo [4];
    logic [63:0] vh [4];
    logic [63:0] ve [4];
    int lat; logic [63:0] res; bit ok;
    va[0] = 32'd2;          vb[0] = 32'd3; vo[0] = 3'b010; vh[0] = 64'h1_0000_0000;
    va[1] = 32'd1;          vb[1] = 32'd1; vo[1] = 3'b100; vh[1] = 64'd0;
    va[2] = 32'hFFFF_FFFF;  vb[2] = 32'd1; vo[2] = 3'b011; vh[2] = 64'd10;
    va[3] = 32'd2;          vb[3] = 32'd3; vo[3] = 3'b110; vh[3] = 64'd5;
`ifdef MULT_ACC_EN
    ve[0] = 64'h1_0000_0006; ve[1] = 64'hFFFF_FFFF_FFFF_FFFF; ve[2] = 64'd9; ve[3] = 64'd6;
`else
    ve[0] = 64'd6; ve[1] = 64'd1; ve[2] = 64'hFFFF_FFFF_FFFF_FFFF; ve[3] = 64'd6;
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vo[i], vh[i], lat, res, ok);
      n_vec++;
      if (!ok || lat != 9 || res !== ve[i]) begin
        n_bad++; $display("FAIL accumulate[%0d] got=%h lat=%0d exp=%h", i, res, lat, ve[i]);
      end
      last_hilo = ve[i];
    end
  endtask

  task automatic test_flush();
    int lat; logic [63:0] res; bit ok; bit seen;
    bus.a = 32'd3; bus.b = 32'd5; bus.op = 3'b000; bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle got ready=%b busy=%b exp ready=1 busy=0", bus.in_ready, bus.busy); end
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    n_vec++; if (seen) begin n_bad++; $display("FAIL flush_no_strobe got=1 exp=0"); end
    n_vec++; if (bus.hilo !== last_hilo) begin n_bad++; $display("FAIL flush_hilo got=%h exp=%h", bus.hilo, last_hilo); end
    // A request coinciding with flush in IDLE is dropped.
    @(posedge clk); #1 bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_drop got busy=%b exp=0", bus.busy); end
    @(posedge clk); #1;
    run_op(32'd6, 32'd7, 3'b000, 64'd0, lat, res, ok);
    n_vec++; if (!ok || res !== 64'd42) begin n_bad++; $display("FAIL after_flush got=%h exp=2a", res); end
    last_hilo = 64'd42;
  endtask

  task automatic test_hold_busy();
    int accepts; bit got; logic [63:0] res;
    accepts = 0; got = 1'b0; res = '0;
    bus.a = 32'd11; bus.b = 32'd13; bus.op = 3'b000; bus.in_valid = 1'b1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready && !bus.flush) accepts++;
      if (bus.out_valid) begin got = 1'b1; res = bus.hilo; end
      @(posedge clk); #1;
      if (!got) begin bus.a = $urandom; bus.b = $urandom; end
    end
    bus.in_valid = 1'b0;
    n_vec++; if (accepts != 1) begin n_bad++; $display("FAIL hold_accepts got=%0d exp=1", accepts); end
    n_vec++; if (!got || res !== 64'd143) begin n_bad++; $display("FAIL hold_result got=%h exp=8f", res); end
    last_hilo = 64'd143;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL hold_idle got busy=%b exp=0", bus.busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_and_done_flush();
    bit seen;
    bus.a = 32'd9; bus.b = 32'd9; bus.op = 3'b000; bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    n_vec++; if (seen) begin n_bad++; $display("FAIL reset_mid_strobe got=1 exp=0"); end
    n_vec++; if (bus.hilo !== 64'd0) begin n_bad++; $display("FAIL reset_mid_hilo got=%h exp=0", bus.hilo); end
    last_hilo = 64'd0;
    @(posedge clk); #1;
    bus.a = 32'd4; bus.b = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL done_flush got busy=%b out_valid=%b exp busy=1 out_valid=0", bus.busy, bus.out_valid); end
    n_vec++; if (bus.hilo !== last_hilo) begin n_bad++; $display("FAIL done_flush_hilo got=%h exp=%h", bus.hilo, last_hilo); end
    @(posedge clk); #1 bus.flush = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    n_vec++; if (seen || bus.hilo !== last_hilo || bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL done_flush_after got strobe=%b hilo=%h exp strobe=0 hilo=%h", seen, bus.hilo, last_hilo); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b; logic [2:0] op; logic [63:0] exp_v, res;
    int lat; bit ok;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom; op = {2'b00, i[0]};
      if (op[0]) exp_v = 64'(longint'($signed(a)) * longint'($signed(b)));
      else       exp_v = {32'd0, a} * {32'd0, b};
      run_op(a, b, op, 64'd0, lat, res, ok);
      n_vec++;
      if (!ok || lat != 9 || res !== exp_v) begin
        n_bad++; $display("FAIL sweep[%0d] a=%h b=%h op=%0d got=%h lat=%0d exp=%h", i, a, b, op, res, lat, exp_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_unsigned();
    test_signed();
    test_accumulate();
    test_flush();
    test_hold_busy();
    test_reset_and_done_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
